block_buffer_ctrl: RTL and testbench

- Parametrised single-block write-back buffer between a sector-granular requester and the AMI memory port.
- Holds one memory block of SECTORS sectors, each SECTOR_W bits wide.
- Serves sector reads/writes on hits.
- On a miss it writes back the dirty block, fills the new block from memory, then serves the request.
- Successor to the fixed 8x64-bit block buffer: generalised geometry, dirty tracking, miss handling.

---
 rtl/block_buffer_ctrl.sv | 170 +++++++++++++++++
 tb/tb_block_buffer_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/block_buffer_ctrl.sv
// Single-block write-back buffer between a sector requester and the AMI memory port.
// Optional flush path enabled by defining BLOCK_BUFFER_FLUSH_EN.
module block_buffer_ctrl #(
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned SECTOR_W = 64,
  parameter int unsigned SECTORS  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_is_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [SECTOR_W-1:0]          req_data,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [SECTOR_W-1:0]          resp_data,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic                         mem_req_is_write,
  output logic [ADDR_W-1:0]            mem_req_addr,
  output logic [SECTOR_W*SECTORS-1:0]  mem_req_data,
  input  logic                         mem_resp_valid,
  input  logic [SECTOR_W*SECTORS-1:0]  mem_resp_data
`ifdef BLOCK_BUFFER_FLUSH_EN
  ,
  input  logic                         flush_req,
  output logic                         flush_done
`endif
);

  localparam int unsigned BLOCK_W = SECTOR_W * SECTORS;
  localparam int unsigned OFF_LSB = $clog2(SECTOR_W / 8);
  localparam int unsigned SEL_W   = $clog2(SECTORS);
  localparam int unsigned TAG_LSB = OFF_LSB + SEL_W;
  localparam int unsigned TAG_W   = ADDR_W - TAG_LSB;

  typedef enum logic [2:0] {IDLE, WB_REQ, FILL_REQ, FILL_WAIT, SERVE, RESP} state_t;

  state_t              state, state_next;
  logic                blk_valid, dirty, flushing;
  logic [TAG_W-1:0]    tag, lat_tag, req_tag, fill_tag;
  logic [SEL_W-1:0]    lat_sel;
  logic                lat_is_write;
  logic [SECTOR_W-1:0] lat_data;
  logic [SECTOR_W-1:0] blk [SECTORS];
  logic [BLOCK_W-1:0]  blk_flat;
  logic                accept, hit, flush_go;

  assign req_tag  = req_addr[ADDR_W-1:TAG_LSB];
  assign hit      = blk_valid && (req_tag == tag);
  assign accept   = req_valid && req_ready;
  // The fill tag comes straight from the request on the accept edge
  assign fill_tag = (state == IDLE) ? req_tag : lat_tag;

`ifdef BLOCK_BUFFER_FLUSH_EN
  assign flush_go  = (state == IDLE) && !resp_valid && flush_req;
  assign req_ready = rst_n && (state == IDLE) && !resp_valid && !flush_req;
`else
  assign flush_go  = 1'b0;
  assign req_ready = rst_n && (state == IDLE) && !resp_valid;
`endif

  if (OFF_LSB > 0) begin : g_off
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[OFF_LSB-1:0];
  end

  always_comb begin
    blk_flat = '0;
    for (int unsigned i = 0; i < SECTORS; i++) blk_flat[i*SECTOR_W +: SECTOR_W] = blk[i];
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (flush_go) begin
          if (blk_valid && dirty) state_next = WB_REQ;
        end else if (accept) begin
          if (hit)                     state_next = SERVE;
          else if (blk_valid && dirty) state_next = WB_REQ;
          else                         state_next = FILL_REQ;
        end
      end
      WB_REQ:    if (mem_req_ready) state_next = flushing ? IDLE : FILL_REQ;
      FILL_REQ:  if (mem_req_ready) state_next = FILL_WAIT;
      FILL_WAIT: if (mem_resp_valid) state_next = SERVE;
      SERVE:     state_next = RESP;
      RESP:      if (resp_ready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Control state, latched request and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_valid        <= 1'b0;
      dirty            <= 1'b0;
      tag              <= '0;
      flushing         <= 1'b0;
      lat_tag          <= '0;
      lat_sel          <= '0;
      lat_is_write     <= 1'b0;
      lat_data         <= '0;
      resp_valid       <= 1'b0;
      resp_data        <= '0;
      mem_req_valid    <= 1'b0;
      mem_req_is_write <= 1'b0;
      mem_req_addr     <= '0;
      mem_req_data     <= '0;
    end else begin
      if (state == IDLE) flushing <= flush_go;
      if (accept) begin
        lat_tag      <= req_tag;
        lat_sel      <= req_addr[TAG_LSB-1:OFF_LSB];
        lat_is_write <= req_is_write;
        lat_data     <= req_data;
      end
      mem_req_valid    <= (state_next == WB_REQ) || (state_next == FILL_REQ);
      mem_req_is_write <= (state_next == WB_REQ);
      if (state_next == WB_REQ) begin
        mem_req_addr <= {tag, TAG_LSB'(0)};
        mem_req_data <= blk_flat;
      end else if (state_next == FILL_REQ) begin
        mem_req_addr <= {fill_tag, TAG_LSB'(0)};
        mem_req_data <= '0;
      end else begin
        mem_req_addr <= '0;
        mem_req_data <= '0;
      end
      if (state == WB_REQ && mem_req_ready) dirty <= 1'b0;
      if (state == FILL_WAIT && mem_resp_valid) begin
        tag       <= lat_tag;
        blk_valid <= 1'b1;
        dirty     <= 1'b0;
      end
      if (state == SERVE) begin
        resp_valid <= 1'b1;
        resp_data  <= lat_is_write ? '0 : blk[lat_sel];
        if (lat_is_write) dirty <= 1'b1;
      end
      if (state == RESP && resp_ready) resp_valid <= 1'b0;
    end
  end

  // Block storage carries no reset
  always_ff @(posedge clk) begin
    if (state == FILL_WAIT && mem_resp_valid) begin
      for (int unsigned i = 0; i < SECTORS; i++) blk[i] <= mem_resp_data[i*SECTOR_W +: SECTOR_W];
    end else if (state == SERVE && lat_is_write) begin
      blk[lat_sel] <= lat_data;
    end
  end

`ifdef BLOCK_BUFFER_FLUSH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flush_done <= 1'b0;
    else        flush_done <= (flush_go && !(blk_valid && dirty)) ||
                              (state == WB_REQ && mem_req_ready && flushing);
  end
`endif

endmodule

// File: tb/tb_block_buffer_ctrl.sv
// Directed self-checking bench for block_buffer_ctrl (default 64-bit, 8x64-bit geometry).
// Flush checks are compiled in when BLOCK_BUFFER_FLUSH_EN is defined.
module tb_block_buffer_ctrl;
  localparam int unsigned BLOCK_W = 512;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req_valid, req_ready, req_is_write;
  logic [63:0]        req_addr, req_data;
  logic               resp_valid, resp_ready;
  logic [63:0]        resp_data;
  logic               mem_req_valid, mem_req_ready, mem_req_is_write;
  logic [63:0]        mem_req_addr;
  logic [BLOCK_W-1:0] mem_req_data;
  logic               mem_resp_valid;
  logic [BLOCK_W-1:0] mem_resp_data;
`ifdef BLOCK_BUFFER_FLUSH_EN
  logic               flush_req, flush_done;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bit                 log_wr[$];
  logic [63:0]        log_addr[$];
  logic [BLOCK_W-1:0] log_data[$];
  logic [BLOCK_W-1:0] exp_blk;

  always #5 clk = ~clk;

  block_buffer_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_write(req_is_write),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_is_write(mem_req_is_write), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
`ifdef BLOCK_BUFFER_FLUSH_EN
    , .flush_req(flush_req), .flush_done(flush_done)
`endif
  );

  task automatic check(input string tag, input logic [BLOCK_W-1:0] got, input logic [BLOCK_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BLOCK_W-1:0] make_block(input logic [15:0] pfx);
    logic [BLOCK_W-1:0] b;
    for (int i = 0; i < 8; i++) b[i*64 +: 64] = {pfx, 32'h0, 16'(i)};
    return b;
  endfunction

  // One request with an inline memory responder; stalls the first mem request and/or the response
  task automatic txn(input string tag, input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [BLOCK_W-1:0] fill, input int req_stall, input int resp_stall,
                     input int exp_nreq, input logic [63:0] exp_rdata);
    int n;
    bit hs, fire, got, hs_wr;
    int stall, rstall;
    logic [63:0] hs_addr;
    logic [BLOCK_W-1:0] hs_data;
    log_wr.delete(); log_addr.delete(); log_data.delete();
    @(negedge clk);
    req_valid = 1'b1; req_is_write = wr; req_addr = addr; req_data = wdata;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check({tag, " accept"}, req_ready, 1'b1);
    hs = 0; fire = 0; got = 0; stall = req_stall; rstall = resp_stall;
    hs_wr = 0; hs_addr = '0; hs_data = '0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      req_valid = 1'b0; mem_resp_valid = 1'b0; resp_ready = 1'b0; mem_req_ready = 1'b0;
      if (hs) begin
        log_wr.push_back(hs_wr); log_addr.push_back(hs_addr); log_data.push_back(hs_data);
        if (!hs_wr) fire = 1;
        hs = 0;
      end
      if (fire) begin
        mem_resp_valid = 1'b1; mem_resp_data = fill; fire = 0;
      end else if (mem_req_valid) begin
        if (stall > 0) begin
          check({tag, " stall addr"}, mem_req_addr, addr & ~64'h3F);
          check({tag, " stall wr"}, mem_req_is_write, 1'b0);
          check({tag, " stall data"}, mem_req_data, '0);
          stall--;
        end else begin
          mem_req_ready = 1'b1; hs = 1;
          hs_wr = mem_req_is_write; hs_addr = mem_req_addr; hs_data = mem_req_data;
        end
      end
      if (resp_valid) begin
        if (rstall > 0) begin
          check({tag, " held rdata"}, resp_data, exp_rdata);
          check({tag, " held req_ready"}, req_ready, 1'b0);
          rstall--;
        end else begin
          check({tag, " rdata"}, resp_data, exp_rdata);
          resp_ready = 1'b1; got = 1;
        end
      end
    end
    check({tag, " response seen"}, got, 1'b1);
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, " mem req count"}, log_addr.size(), exp_nreq);
  endtask

`ifdef BLOCK_BUFFER_FLUSH_EN
  task automatic flush_run(input string tag, input int exp_nmem, input logic [BLOCK_W-1:0] exp_data,
                           input int exp_first);
    int ndone, nmem, first;
    ndone = 0; nmem = 0; first = -1;
    @(negedge clk); flush_req = 1'b1;
    @(negedge clk); flush_req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      mem_req_ready = 1'b0;
      if (flush_done) begin ndone++; if (first < 0) first = c; end
      if (mem_req_valid) begin
        nmem++;
        check({tag, " wb addr"}, mem_req_addr, 64'h1000);
        check({tag, " wb wr"}, mem_req_is_write, 1'b1);
        check({tag, " wb data"}, mem_req_data, exp_data);
        mem_req_ready = 1'b1;
      end
    end
    mem_req_ready = 1'b0;
    check({tag, " mem count"}, nmem, exp_nmem);
    check({tag, " done count"}, ndone, 1);
    check({tag, " done cycle"}, first, exp_first);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_is_write = 1'b0; req_addr = '0; req_data = '0;
    resp_ready = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
`ifdef BLOCK_BUFFER_FLUSH_EN
    flush_req = 1'b0;
`endif
    #1;
    check("rst req_ready", req_ready, 1'b0);
    check("rst resp_valid", resp_valid, 1'b0);
    check("rst resp_data", resp_data, '0);
    check("rst mem_req_valid", mem_req_valid, 1'b0);
    check("rst mem_req_addr", mem_req_addr, '0);
    check("rst mem_req_data", mem_req_data, '0);
`ifdef BLOCK_BUFFER_FLUSH_EN
    check("rst flush_done", flush_done, 1'b0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst req_ready", req_ready, 1'b1);

    // Clean miss with the fill request stalled for 5 cycles
    txn("rd 1000", 1'b0, 64'h1000, 64'h0, make_block(16'hAAAA), 5, 0, 1, 64'hAAAA_0000_0000_0000);
    check("fill addr", log_addr[0], 64'h1000);
    check("fill wr", log_wr[0], 1'b0);
    check("fill data", log_data[0], '0);

    txn("rd 1010", 1'b0, 64'h1010, 64'h0, '0, 0, 0, 0, 64'hAAAA_0000_0000_0002);
    txn("wr 1018", 1'b1, 64'h1018, 64'hDEAD_BEEF_0000_0001, '0, 0, 0, 0, 64'h0);
    // Hit read with response back-pressured for 3 cycles
    txn("rd 1018", 1'b0, 64'h1018, 64'h0, '0, 0, 3, 0, 64'hDEAD_BEEF_0000_0001);

    // Dirty miss: writeback of old block, then fill of the new one
    exp_blk = make_block(16'hAAAA);
    exp_blk[3*64 +: 64] = 64'hDEAD_BEEF_0000_0001;
    txn("rd 2040", 1'b0, 64'h2040, 64'h0, make_block(16'hBBBB), 0, 0, 2, 64'hBBBB_0000_0000_0000);
    check("wb wr", log_wr[0], 1'b1);
    check("wb addr", log_addr[0], 64'h1000);
    check("wb data", log_data[0], exp_blk);
    check("refill wr", log_wr[1], 1'b0);
    check("refill addr", log_addr[1], 64'h2040);
    check("refill data", log_data[1], '0);
    txn("rd 2048", 1'b0, 64'h2048, 64'h0, '0, 0, 0, 0, 64'hBBBB_0000_0000_0001);

    // Reset while waiting for fill data; the late response must be ignored
    @(negedge clk);
    req_valid = 1'b1; req_is_write = 1'b0; req_addr = 64'h1000;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    check("abort fill valid", mem_req_valid, 1'b1);
    check("abort fill addr", mem_req_addr, 64'h1000);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort rst mem_req_valid", mem_req_valid, 1'b0);
    check("abort rst req_ready", req_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = make_block(16'hEEEE);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check("stray resp_valid", resp_valid, 1'b0);
    check("stray mem_req_valid", mem_req_valid, 1'b0);
    check("stray req_ready", req_ready, 1'b1);
    txn("rd 1000 refill", 1'b0, 64'h1000, 64'h0, make_block(16'hCCCC), 0, 0, 1, 64'hCCCC_0000_0000_0000);
    check("refill after rst addr", log_addr[0], 64'h1000);

`ifdef BLOCK_BUFFER_FLUSH_EN
    txn("wr 1008", 1'b1, 64'h1008, 64'h1234_5678_9ABC_DEF0, '0, 0, 0, 0, 64'h0);
    exp_blk = make_block(16'hCCCC);
    exp_blk[1*64 +: 64] = 64'h1234_5678_9ABC_DEF0;
    flush_run("flush dirty", 1, exp_blk, 1);
    flush_run("flush clean", 0, exp_blk, 0);
    txn("rd 1008 post flush", 1'b0, 64'h1008, 64'h0, '0, 0, 0, 0, 64'h1234_5678_9ABC_DEF0);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
